// File: rtl/miter_response_monitor.sv
// Campaign monitor for golden/faulty result pairs: counts samples and mismatches and captures the first mismatch.
// Optional MISR signatures of both result streams are built when MISR_SIGNATURE_EN is defined.
module miter_response_monitor #(
  parameter int RESULT_PRECISION = 32,
  parameter int TOTAL_SAMPLES    = 1024,
`ifdef MISR_SIGNATURE_EN
  parameter logic [RESULT_PRECISION-1:0] MISR_POLY = 32'h04C11DB7,
`endif
  parameter int CNT_W            = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic signed [RESULT_PRECISION-1:0] gm_result_i,
  input  logic signed [RESULT_PRECISION-1:0] fm_result_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [CNT_W-1:0]                   sample_cnt_o,
  output logic [CNT_W-1:0]                   mismatch_cnt_o,
  output logic                               mismatch_o,
  output logic [CNT_W-1:0]                   first_idx_o,
  output logic [RESULT_PRECISION-1:0]        first_gm_o,
  output logic [RESULT_PRECISION-1:0]        first_fm_o,
`ifdef MISR_SIGNATURE_EN
  output logic [RESULT_PRECISION-1:0]        gm_sig_o,
  output logic [RESULT_PRECISION-1:0]        fm_sig_o,
`endif
  output logic [1:0]                         dbg_state_o
);

  // Handshake: a pair transfers on a rising edge where in_valid_i && in_ready_o.
  // in_ready_o depends on the state register only, never on in_valid_i.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                      state_q;
  logic [CNT_W-1:0]            sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]            mismatch_cnt_q, mismatch_cnt_d;
  logic                        mismatch_q;
  logic [CNT_W-1:0]            first_idx_q;
  logic [RESULT_PRECISION-1:0] first_gm_q, first_fm_q;
  logic                        accept;
  logic                        pair_differs;

  assign accept       = in_valid_i && (state_q == S_COLLECT);
  assign pair_differs = (gm_result_i != fm_result_i);

  always_comb begin
    sample_cnt_d   = sample_cnt_q + 1'b1;
    mismatch_cnt_d = mismatch_cnt_q;
    if (mismatch_cnt_q != CNT_MAX) begin
      mismatch_cnt_d = mismatch_cnt_q + 1'b1;
    end
  end

`ifdef MISR_SIGNATURE_EN
  logic [RESULT_PRECISION-1:0] gm_sig_q, fm_sig_q;

  function automatic logic [RESULT_PRECISION-1:0] misr_step(
    input logic [RESULT_PRECISION-1:0] sig,
    input logic [RESULT_PRECISION-1:0] data
  );
    return {sig[RESULT_PRECISION-2:0], 1'b0}
           ^ (sig[RESULT_PRECISION-1] ? MISR_POLY : '0) ^ data;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      gm_sig_q <= '0;
      fm_sig_q <= '0;
    end else if (start_i && (state_q != S_COLLECT)) begin
      gm_sig_q <= '1;
      fm_sig_q <= '1;
    end else if (accept) begin
      gm_sig_q <= misr_step(gm_sig_q, gm_result_i);
      fm_sig_q <= misr_step(fm_sig_q, fm_result_i);
    end
  end

  assign gm_sig_o = gm_sig_q;
  assign fm_sig_o = fm_sig_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      mismatch_q     <= 1'b0;
      first_idx_q    <= '0;
      first_gm_q     <= '0;
      first_fm_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q        <= S_COLLECT;
            sample_cnt_q   <= '0;
            mismatch_cnt_q <= '0;
            mismatch_q     <= 1'b0;
            first_idx_q    <= '0;
            first_gm_q     <= '0;
            first_fm_q     <= '0;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            sample_cnt_q <= sample_cnt_d;
            if (pair_differs) begin
              mismatch_cnt_q <= mismatch_cnt_d;
              // Only the first mismatch of a campaign is captured.
              if (!mismatch_q) begin
                mismatch_q  <= 1'b1;
                first_idx_q <= sample_cnt_q;
                first_gm_q  <= gm_result_i;
                first_fm_q  <= fm_result_i;
              end
            end
            if (sample_cnt_q == LAST_IDX) begin
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o     = (state_q == S_COLLECT);
  assign busy_o         = (state_q == S_COLLECT);
  assign done_o         = (state_q == S_DONE);
  assign sample_cnt_o   = sample_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign mismatch_o     = mismatch_q;
  assign first_idx_o    = first_idx_q;
  assign first_gm_o     = first_gm_q;
  assign first_fm_o     = first_fm_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_miter_response_monitor.sv
// Bench for miter_response_monitor: reference model feeds an expected queue, a negedge monitor pops on every accept.
// Signature checks are compiled in when MISR_SIGNATURE_EN is defined.
module tb_miter_response_monitor;

  localparam int W     = 32;
  localparam int CW    = 16;
  localparam int TS    = 1024;
  localparam int EXP_W = 3 + 3 * CW + 2 * W;
  localparam int MAXC  = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start_i = 1'b0, in_valid_i = 1'b0, in_ready_o;
  logic [W-1:0]  gm_result_i = '0, fm_result_i = '0;
  logic          busy_o, done_o, mismatch_o;
  logic [CW-1:0] sample_cnt_o, mismatch_cnt_o, first_idx_o;
  logic [W-1:0]  first_gm_o, first_fm_o;
  logic [1:0]    dbg_state_o;
`ifdef MISR_SIGNATURE_EN
  logic [W-1:0]  gm_sig_o, fm_sig_o, s_gm_sig, s_fm_sig;
`endif

  miter_response_monitor #(.RESULT_PRECISION(W), .TOTAL_SAMPLES(TS), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .gm_result_i(gm_result_i), .fm_result_i(fm_result_i),
    .busy_o(busy_o), .done_o(done_o), .sample_cnt_o(sample_cnt_o),
    .mismatch_cnt_o(mismatch_cnt_o), .mismatch_o(mismatch_o), .first_idx_o(first_idx_o),
    .first_gm_o(first_gm_o), .first_fm_o(first_fm_o),
`ifdef MISR_SIGNATURE_EN
    .gm_sig_o(gm_sig_o), .fm_sig_o(fm_sig_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // Small saturation instance: 4 samples, 2-bit counters.
  logic         s_start = 1'b0, s_valid = 1'b0, s_ready, s_busy, s_done, s_mism;
  logic [W-1:0] s_gm = '0, s_fm = '0, s_fgm, s_ffm;
  logic [1:0]   s_cnt, s_mcnt, s_fidx, s_state;

  miter_response_monitor #(.RESULT_PRECISION(W), .TOTAL_SAMPLES(4), .CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .start_i(s_start), .in_valid_i(s_valid),
    .in_ready_o(s_ready), .gm_result_i(s_gm), .fm_result_i(s_fm),
    .busy_o(s_busy), .done_o(s_done), .sample_cnt_o(s_cnt),
    .mismatch_cnt_o(s_mcnt), .mismatch_o(s_mism), .first_idx_o(s_fidx),
    .first_gm_o(s_fgm), .first_fm_o(s_ffm),
`ifdef MISR_SIGNATURE_EN
    .gm_sig_o(s_gm_sig), .fm_sig_o(s_fm_sig),
`endif
    .dbg_state_o(s_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int           m_phase;   // 0 idle, 1 collecting, 2 done
  int           m_n, m_mm, m_fidx;
  bit           m_seen;
  logic [W-1:0] m_fgm, m_ffm;
  logic [EXP_W-1:0] exp_q[$];

  task automatic model_clear(input int phase);
    m_phase = phase; m_n = 0; m_mm = 0; m_fidx = 0; m_seen = 0; m_fgm = '0; m_ffm = '0;
  endtask

  function automatic logic [EXP_W-1:0] model_snapshot();
    int mc;
    mc = (m_mm > MAXC) ? MAXC : m_mm;
    return {m_phase == 2, m_phase == 1, m_seen, CW'(m_n), CW'(mc), CW'(m_fidx), m_fgm, m_ffm};
  endfunction

  function automatic logic [EXP_W-1:0] dut_snapshot();
    return {done_o, busy_o, mismatch_o, sample_cnt_o, mismatch_cnt_o, first_idx_o,
            first_gm_o, first_fm_o};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit st, input bit v, input logic [W-1:0] g, input logic [W-1:0] f);
    start_i = st; in_valid_i = v; gm_result_i = g; fm_result_i = f;
    if (m_phase == 1 && v) begin
      if (g != f) begin
        m_mm++;
        if (!m_seen) begin
          m_seen = 1; m_fidx = m_n; m_fgm = g; m_ffm = f;
        end
      end
      m_n++;
      if (m_n == TS) m_phase = 2;
      exp_q.push_back(model_snapshot());
    end else if (st && m_phase != 1) begin
      model_clear(1);
    end
    @(posedge clock); #1;
    start_i = 1'b0; in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start_i = 1'b0; in_valid_i = 1'b0;
    s_start = 1'b0; s_valid = 1'b0;
    model_clear(0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cnt"}, sample_cnt_o, 0);
    chk({name, "_mcnt"}, mismatch_cnt_o, 0);
    chk({name, "_flags"}, {done_o, busy_o, mismatch_o, in_ready_o}, 0);
    chk({name, "_first"}, {first_idx_o, first_gm_o ^ first_fm_o, first_gm_o}, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  bit pend = 0;
  always @(negedge clock) begin
    logic [EXP_W-1:0] e;
    if (pend) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_accept: got %0h expected no accept", dut_snapshot());
      end else begin
        e = exp_q.pop_front();
        if (dut_snapshot() !== e) begin
          n_fail++;
          $display("FAIL sb_accept: got %0h expected %0h", dut_snapshot(), e);
        end
      end
    end
    pend = in_valid_i && in_ready_o && !reset;
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear(0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_all_zero("reset");
    chk("reset_state", dbg_state_o, 0);

    // Pairs in IDLE are dropped.
    for (int i = 0; i < 3; i++) step(0, 1, $urandom, $urandom);
    chk("idle_drop", sample_cnt_o, 0);

    // Clean campaign, GM = FM = i.
    step(1, 0, 0, 0);
    for (int i = 0; i < TS; i++) step(0, 1, i, i);
    chk("t1_done", {done_o, busy_o}, 2'b10);
    chk("t1_cnt", sample_cnt_o, TS);
    chk("t1_mism", {mismatch_cnt_o, mismatch_o}, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 7, 8);
    chk("done_drop", {sample_cnt_o, mismatch_o}, {CW'(TS), 1'b0});

    // Two planted mismatches.
    step(1, 0, 0, 0);
    for (int i = 0; i < TS; i++) step(0, 1, i, (i == 5 || i == 900) ? (i ^ 1) : i);
    chk("t2_mcnt", mismatch_cnt_o, 2);
    chk("t2_mism", mismatch_o, 1);
    chk("t2_fidx", first_idx_o, 5);
    chk("t2_fgm", first_gm_o, 5);
    chk("t2_ffm", first_fm_o, 4);

    // Toggling valid.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, (i % 2) == 0, $urandom, $urandom);
    chk("t3_cnt", sample_cnt_o, 3);

    // Reset mid-campaign, start ignored while collecting.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(i == 50, 1, i, i);
    chk("t4_cnt", sample_cnt_o, 100);
    do_reset();
    chk_all_zero("t4_reset");
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, $urandom, $urandom);
    chk("t4_recount", sample_cnt_o, 10);

`ifdef MISR_SIGNATURE_EN
    do_reset();
    chk("sig_reset", {gm_sig_o, fm_sig_o}, 0);
    step(1, 0, 0, 0);
    chk("sig_seed", {gm_sig_o, fm_sig_o}, {32'hFFFFFFFF, 32'hFFFFFFFF});
    step(0, 1, 0, 0);
    chk("sig_gm", gm_sig_o, 32'hFB3EE249);
    chk("sig_fm", fm_sig_o, 32'hFB3EE249);
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    chk("sig_differ", gm_sig_o != fm_sig_o, 1);
    chk("sig_fm1", fm_sig_o, 32'hFB3EE248);
`endif

    // Randomized campaign with gaps, occasional faults and stray starts.
    do_reset();
    step(1, 0, 0, 0);
    for (int c = 0; c < 8000 && m_phase == 1; c++) begin
      logic [W-1:0] g, f;
      g = $urandom;
      f = ($urandom_range(0, 15) == 0) ? (g ^ (32'h1 << $urandom_range(0, 31))) : g;
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, g, f);
    end
    chk("rand_done", done_o, 1);

    // Saturation on the 4-sample instance.
    s_start = 1'b1; @(posedge clock); #1; s_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_gm = k; s_fm = ~k;
      @(posedge clock); #1;
      if (k == 2) begin
        chk("t5_mcnt3", s_mcnt, 3);
        chk("t5_not_done", s_done, 0);
      end
    end
    s_valid = 1'b0;
    chk("t5_sat", s_mcnt, 3);
    chk("t5_done", {s_done, s_busy}, 2'b10);
    chk("t5_first", {s_mism, s_fidx, s_fgm, s_ffm}, {1'b1, 2'd0, 32'd0, 32'hFFFFFFFF});

    @(negedge clock); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
